hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl_pkg.sv | 27 ++
 rtl/hazard_ctrl_if.sv | 35 +++
 rtl/hazard_ctrl_inflight.sv | 64 ++++++
 rtl/hazard_ctrl.sv | 108 ++++++++++
 tb/tb_hazard_ctrl.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the hazard controller.
//   state_e  : controller FSM states (normal issue vs. multiply occupying EX)
//   entry_t  : one in-flight tracker entry {valid, wr, is_load, rdst}
//   entry_hits_reg : true when an entry holds a pending write to a register
package hazard_ctrl_pkg;

   localparam int unsigned MulCyclesDefault = 4;
   // rdst is stored at a fixed width so the struct can live here; REG_W must not exceed it.
   localparam int unsigned RdstMaxW = 8;

   typedef enum logic [0:0] {
      StRun,
      StMulBusy
   } state_e;

   typedef struct packed {
      logic                valid;
      logic                wr;
      logic                is_load;
      logic [RdstMaxW-1:0] rdst;
   } entry_t;

   function automatic logic entry_hits_reg(entry_t e, logic [RdstMaxW-1:0] r);
      return e.valid & e.wr & (e.rdst == r);
   endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Decode/EX-side signals of the hazard controller.
//   master : drives decode fields and ex_taken, observes pipeline controls
//   slave  : the controller; consumes decode fields, drives stall/bubble/flush/busy/pending
interface hazard_ctrl_if #(
   parameter int unsigned REG_W = 3
);
   logic               id_valid;
   logic [REG_W-1:0]   id_rsrc1;
   logic [REG_W-1:0]   id_rsrc2;
   logic               id_use1;
   logic               id_use2;
   logic [REG_W-1:0]   id_rdst;
   logic               id_wr;
   logic               id_is_load;
   logic               id_is_mul;
   logic               ex_taken;
   logic               stall_if;
   logic               stall_id;
   logic               bubble_ex;
   logic               flush_id;
   logic               busy;
   logic [2**REG_W-1:0] pending;

   modport master (
      output id_valid, id_rsrc1, id_rsrc2, id_use1, id_use2, id_rdst, id_wr, id_is_load,
             id_is_mul, ex_taken,
      input  stall_if, stall_id, bubble_ex, flush_id, busy, pending
   );

   modport slave (
      input  id_valid, id_rsrc1, id_rsrc2, id_use1, id_use2, id_rdst, id_wr, id_is_load,
             id_is_mul, ex_taken,
      output stall_if, stall_id, bubble_ex, flush_id, busy, pending
   );
endinterface

// File: rtl/hazard_ctrl_inflight.sv
// Three-entry in-flight tracker (EX, ME, WB).
//   clk, rst  : clock, synchronous active-high reset (clears all entries)
//   shift     : EX <= new_entry (or empty if bubble), ME <= EX, WB <= ME
//   freeze    : EX held, ME <= empty, WB <= ME (takes precedence over shift)
//   bubble    : with shift, insert an empty entry into EX instead of new_entry
//   new_entry : decode fields to load into EX
//   ex_entry  : current EX entry
//   pending   : per-register bitmap of writes still in flight
module inflight_tracker
   import hazard_ctrl_pkg::*;
#(
   parameter int unsigned REG_W = 3
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                shift,
   input  logic                freeze,
   input  logic                bubble,
   input  entry_t              new_entry,
   output entry_t              ex_entry,
   output logic [2**REG_W-1:0] pending
);

   entry_t ex_q, me_q, wb_q;
   entry_t ex_d, me_d, wb_d;

   always_comb begin
      ex_d = ex_q;
      me_d = me_q;
      wb_d = wb_q;
      if (freeze) begin
         me_d = '0;
         wb_d = me_q;
      end else if (shift) begin
         ex_d = bubble ? '0 : new_entry;
         me_d = ex_q;
         wb_d = me_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ex_q <= '0;
         me_q <= '0;
         wb_q <= '0;
      end else begin
         ex_q <= ex_d;
         me_q <= me_d;
         wb_q <= wb_d;
      end
   end

   // Register 0 is tracked like any other register.
   always_comb begin
      pending = '0;
      for (int r = 0; r < 2**REG_W; r++) begin
         pending[r] = entry_hits_reg(ex_q, RdstMaxW'(r)) | entry_hits_reg(me_q, RdstMaxW'(r)) |
                      entry_hits_reg(wb_q, RdstMaxW'(r));
      end
   end

   assign ex_entry = ex_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, taken-branch flush, multi-cycle multiply hold.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of hazard_ctrl_if (decode fields, ex_taken in; stall_if, stall_id,
//              bubble_ex, flush_id, busy, pending out). All outputs are combinational.
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int unsigned MUL_CYCLES = MulCyclesDefault,
   parameter int unsigned REG_W      = 3
) (
   input logic           clk,
   input logic           rst,
   hazard_ctrl_if.slave  bus
);

   state_e     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;

   entry_t ex_entry;
   entry_t new_entry;
   logic   shift, freeze, bubble;
   logic   load_use;
   logic   stall, bubble_ex, flush_id, busy;
   logic [RdstMaxW-1:0] rs1_ext, rs2_ext;

   assign rs1_ext = RdstMaxW'(bus.id_rsrc1);
   assign rs2_ext = RdstMaxW'(bus.id_rsrc2);

   assign new_entry = '{valid:   bus.id_valid,
                        wr:      bus.id_wr,
                        is_load: bus.id_is_load,
                        rdst:    RdstMaxW'(bus.id_rdst)};

   // Only loads stall: other producers are assumed forwarded from EX.
   assign load_use = bus.id_valid & ex_entry.valid & ex_entry.wr & ex_entry.is_load &
                     ((bus.id_use1 & (rs1_ext == ex_entry.rdst)) |
                      (bus.id_use2 & (rs2_ext == ex_entry.rdst)));

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      shift     = 1'b0;
      freeze    = 1'b0;
      bubble    = 1'b0;
      stall     = 1'b0;
      bubble_ex = 1'b0;
      flush_id  = 1'b0;
      busy      = 1'b0;
      case (state_q)
         StRun: begin
            shift = 1'b1;
            if (bus.ex_taken) begin
               flush_id  = 1'b1;
               bubble_ex = 1'b1;
               bubble    = 1'b1;
            end else if (load_use) begin
               // Bubble goes into EX, so the hazard clears next cycle.
               stall     = 1'b1;
               bubble_ex = 1'b1;
               bubble    = 1'b1;
            end else if (bus.id_valid && bus.id_is_mul) begin
               state_d = StMulBusy;
               cnt_d   = 4'(MUL_CYCLES - 1);
            end
         end
         StMulBusy: begin
            freeze = 1'b1;
            stall  = 1'b1;
            busy   = 1'b1;
            cnt_d  = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               state_d = StRun;
            end
         end
         default: state_d = StRun;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StRun;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   inflight_tracker #(
      .REG_W (REG_W)
   ) u_tracker (
      .clk       (clk),
      .rst       (rst),
      .shift     (shift),
      .freeze    (freeze),
      .bubble    (bubble),
      .new_entry (new_entry),
      .ex_entry  (ex_entry),
      .pending   (bus.pending)
   );

   assign bus.stall_if  = stall;
   assign bus.stall_id  = stall;
   assign bus.bubble_ex = bubble_ex;
   assign bus.flush_id  = flush_id;
   assign bus.busy      = busy;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (MUL_CYCLES=4, REG_W=3).
// Control outputs are compared as {stall_if, stall_id, bubble_ex, flush_id, busy}.
module tb_hazard_ctrl;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   hazard_ctrl_if #(.REG_W(3)) bus ();

   hazard_ctrl #(
      .MUL_CYCLES (4),
      .REG_W      (3)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic drive(input logic v, input logic [2:0] rs1, input logic u1,
                        input logic [2:0] rs2, input logic u2, input logic [2:0] rd,
                        input logic wr, input logic ld, input logic mul, input logic tk);
      bus.id_valid   = v;
      bus.id_rsrc1   = rs1;
      bus.id_use1    = u1;
      bus.id_rsrc2   = rs2;
      bus.id_use2    = u2;
      bus.id_rdst    = rd;
      bus.id_wr      = wr;
      bus.id_is_load = ld;
      bus.id_is_mul  = mul;
      bus.ex_taken   = tk;
      #1;
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_ctl(input string tag, input logic [4:0] exp);
      check(tag, 32'({bus.stall_if, bus.stall_id, bus.bubble_ex, bus.flush_id, bus.busy}),
            32'(exp));
   endtask

   task automatic chk_pend(input string tag, input logic [7:0] exp);
      check(tag, 32'(bus.pending), 32'(exp));
   endtask

   task automatic drain();
      idle();
      tick();
      tick();
      tick();
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst    = 1'b1;
      idle();
      tick();
      tick();
      chk_ctl("reset_ctl", 5'b00000);
      chk_pend("reset_pend", 8'h00);
      rst = 1'b0;
      tick();
      chk_ctl("post_reset_ctl", 5'b00000);
      chk_pend("post_reset_pend", 8'h00);

      // Load r3 followed by a reader of r3 via source 1.
      drive(1, 0, 0, 0, 0, 3, 1, 1, 0, 0);
      chk_ctl("ld3_accept_ctl", 5'b00000);
      tick();
      drive(1, 3, 1, 0, 0, 4, 1, 0, 0, 0);
      chk_ctl("ld3_use_stall", 5'b11100);
      chk_pend("ld3_pend_c1", 8'h08);
      tick();
      chk_ctl("ld3_use_release", 5'b00000);
      chk_pend("ld3_pend_c2", 8'h08);
      tick();
      // r4 producer (non-load) in EX: reading it must not stall.
      drive(1, 4, 1, 0, 0, 0, 0, 0, 0, 0);
      chk_ctl("alu_in_ex_no_stall", 5'b00000);
      chk_pend("ld3_pend_c3", 8'h18);
      tick();
      idle();
      chk_pend("ld3_gone", 8'h10);
      drain();
      chk_pend("drain1", 8'h00);

      // Load r3 with sources named but unused: no stall.
      drive(1, 0, 0, 0, 0, 3, 1, 1, 0, 0);
      tick();
      drive(1, 3, 0, 3, 0, 1, 0, 0, 0, 0);
      chk_ctl("ld3_unused_no_stall", 5'b00000);
      tick();

      // Load r6 hit via source 2.
      drive(1, 0, 0, 0, 0, 6, 1, 1, 0, 0);
      tick();
      drive(1, 1, 1, 6, 1, 2, 1, 0, 0, 0);
      chk_ctl("ld6_src2_stall", 5'b11100);
      drain();

      // Load r0 then a reader of r0: r0 has no special treatment.
      drive(1, 0, 0, 0, 0, 0, 1, 1, 0, 0);
      tick();
      drive(1, 0, 1, 0, 0, 1, 0, 0, 0, 0);
      chk_ctl("ld0_stall", 5'b11100);
      chk_pend("ld0_pend", 8'h01);
      drain();

      // Taken branch coincident with a load-use hazard: flush wins.
      drive(1, 0, 0, 0, 0, 2, 1, 1, 0, 0);
      tick();
      drive(1, 2, 1, 0, 0, 5, 1, 0, 0, 1);
      chk_ctl("taken_over_loaduse", 5'b00110);
      tick();
      idle();
      chk_ctl("after_taken_ctl", 5'b00000);
      chk_pend("after_taken_pend", 8'h04);
      drain();
      chk_pend("drain2", 8'h00);

      // Multiply r5: three busy cycles; id_* and ex_taken ignored meanwhile.
      drive(1, 0, 0, 0, 0, 5, 1, 0, 1, 0);
      chk_ctl("mul_accept_ctl", 5'b00000);
      tick();
      for (int i = 0; i < 3; i++) begin
         drive(1, 5, 1, 5, 1, 7, 1, 1, 1, 1);
         chk_ctl($sformatf("mul_busy_%0d", i), 5'b11001);
         chk_pend($sformatf("mul_pend_%0d", i), 8'h20);
         tick();
      end
      idle();
      chk_ctl("mul_done_ctl", 5'b00000);
      chk_pend("mul_done_pend", 8'h20);
      tick();
      chk_pend("mul_in_me", 8'h20);
      drain();
      chk_pend("mul_drained_no_r7", 8'h00);

      // Reset on the second busy cycle aborts the multiply.
      drive(1, 0, 0, 0, 0, 5, 1, 0, 1, 0);
      tick();
      idle();
      chk_ctl("mul2_busy1", 5'b11001);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk_ctl("mul_abort_ctl", 5'b00000);
      chk_pend("mul_abort_pend", 8'h00);
      tick();
      chk_ctl("mul_abort_run", 5'b00000);

      // Back-to-back writes r1, r2, r1.
      drive(1, 0, 0, 0, 0, 1, 1, 0, 0, 0);
      chk_pend("b2b_c0", 8'h00);
      tick();
      drive(1, 0, 0, 0, 0, 2, 1, 0, 0, 0);
      chk_pend("b2b_c1", 8'h02);
      tick();
      drive(1, 0, 0, 0, 0, 1, 1, 0, 0, 0);
      chk_pend("b2b_c2", 8'h06);
      tick();
      idle();
      chk_pend("b2b_c3", 8'h06);
      tick();
      chk_pend("b2b_c4", 8'h06);
      tick();
      chk_pend("b2b_c5", 8'h02);
      tick();
      chk_pend("b2b_c6", 8'h00);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
